// File: rtl/tetris_pkg.sv
// tetris_pkg: definitions shared by the Tetris command scheduler and game logic.
//   - cmd_e          : command encoding on cmd_code (must match game-logic act codes)
//   - SC_*           : PS/2 set-2 scan codes the scheduler reacts to
//   - sched_state_e  : scheduler state
//   - decode_move()  : maps a make code to a move command (hit=0 if not a move key)
package tetris_pkg;

    typedef enum logic [1:0] {
        CMD_FALL   = 2'd0,
        CMD_LEFT   = 2'd1,
        CMD_RIGHT  = 2'd2,
        CMD_ROTATE = 2'd3
    } cmd_e;

    localparam logic [7:0] SC_LEFT   = 8'h1C;
    localparam logic [7:0] SC_RIGHT  = 8'h23;
    localparam logic [7:0] SC_ROTATE = 8'h1D;
    localparam logic [7:0] SC_FALL   = 8'h1B;
    localparam logic [7:0] SC_PAUSE  = 8'h29;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic hit;
        cmd_e code;
    } move_dec_t;

    function automatic move_dec_t decode_move(input logic [7:0] sc);
        move_dec_t d;
        d.hit  = 1'b1;
        d.code = CMD_FALL;
        case (sc)
            SC_LEFT:   d.code = CMD_LEFT;
            SC_RIGHT:  d.code = CMD_RIGHT;
            SC_ROTATE: d.code = CMD_ROTATE;
            SC_FALL:   d.code = CMD_FALL;
            default:   d.hit  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tetris_cmd_fifo.sv
// tetris_cmd_fifo: small synchronous FIFO of 2-bit commands.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_push/i_din  write request / data (ignored when full unless popping)
//   i_pop         read request (ignored when empty)
//   i_flush       empties the FIFO, overrides push/pop
//   o_dout        head entry (valid when !o_empty)
//   o_full/o_empty status
module tetris_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [1:0] i_din,
    input  logic       i_pop,
    input  logic       i_flush,
    output logic [1:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] r_wptr, r_rptr;
    logic [1:0]  r_mem [DEPTH];
    logic        w_do_push, w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_dout    = r_mem[r_rptr[AW-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/tetris_cmd_sched.sv
// tetris_cmd_sched: decodes PS/2 scan codes into move commands, generates the
// level-dependent gravity tick and merges both onto one valid/ready command port.
// Owns the IDLE/RUN/PAUSED state.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   kb_data, kb_ready   scan byte; each kb_ready 0->1 delivers one byte
//   game_run            1 = game active, 0 = idle / game over
//   level               difficulty level, sets the gravity period
//   cmd_valid/cmd_code/cmd_ready  command stream to game logic (0 FALL,1 LEFT,2 RIGHT,3 ROTATE)
//   paused              1 while PAUSED
//   fifo_ovf            sticky, a keyboard command was dropped on a full FIFO
// Build option: define TETRIS_CMD_AUTOREPEAT_EN to suppress typematic repeats of
// move keys (one command per key hold, re-armed by the key's break code).
module tetris_cmd_sched
    import tetris_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 32,
    parameter int BASE_PERIOD = 35_000_000,
    parameter int STEP_PERIOD = 2_000_000,
    parameter int MIN_PERIOD  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    input  logic       game_run,
    input  logic [3:0] level,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    input  logic       cmd_ready,
    output logic       paused,
    output logic       fifo_ovf
);
    // Period math is done 4 bits wider than the counter so level*STEP never wraps.
    localparam int PW = CNT_W + 4;

    sched_state_e     r_state, w_state_nxt;
    logic             r_kb_ready_d, r_brk_pend, r_grav_pend;
    logic             r_cmd_valid, r_paused, r_fifo_ovf;
    cmd_e             r_cmd_code;
    logic [CNT_W-1:0] r_cnt;

    logic             w_kb_edge, w_byte_live, w_brk_code, w_pause_byte, w_rep_ok;
    logic             w_run_stay, w_enter_pause, w_flush, w_enq, w_tick;
    logic             w_launch, w_sel_grav, w_sel_fifo;
    logic             w_fifo_full, w_fifo_empty;
    logic [1:0]       w_fifo_dout;
    logic [PW-1:0]    w_reduce, w_period;
    move_dec_t        w_mv;

    // ---------------- keyboard byte classification ----------------
    assign w_kb_edge    = kb_ready && !r_kb_ready_d;
    // E0 prefixes are transparent: they neither count as a byte nor consume a break.
    assign w_byte_live  = w_kb_edge && !r_brk_pend && (kb_data != SC_EXT);
    assign w_brk_code   = w_kb_edge &&  r_brk_pend && (kb_data != SC_EXT);
    assign w_pause_byte = w_byte_live && (kb_data == SC_PAUSE);
    assign w_mv         = decode_move(kb_data);

    // ---------------- state machine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (game_run)     w_state_nxt = ST_RUN;
            ST_RUN:    if (w_pause_byte) w_state_nxt = ST_PAUSED;
            ST_PAUSED: if (w_pause_byte) w_state_nxt = ST_RUN;
            default:                     w_state_nxt = ST_IDLE;
        endcase
        if (!game_run) w_state_nxt = ST_IDLE;
    end

    assign w_run_stay    = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
    assign w_enter_pause = (r_state == ST_RUN) && (w_state_nxt == ST_PAUSED);
    assign w_flush       = !game_run || w_enter_pause;

    // ---------------- repeat filter ----------------
`ifdef TETRIS_CMD_AUTOREPEAT_EN
    logic [3:0] r_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held <= '0;
        end else if (!game_run) begin
            r_held <= '0;
        end else begin
            if (w_byte_live && w_mv.hit && (r_state == ST_RUN)) r_held[w_mv.code] <= 1'b1;
            if (w_brk_code && w_mv.hit)                         r_held[w_mv.code] <= 1'b0;
        end
    end

    assign w_rep_ok = !r_held[w_mv.code];
`else
    assign w_rep_ok = 1'b1;
`endif

    assign w_enq = w_byte_live && w_mv.hit && w_rep_ok && w_run_stay;

    // ---------------- gravity ----------------
    assign w_reduce = PW'(level) * PW'(STEP_PERIOD);

    always_comb begin
        w_period = PW'(BASE_PERIOD) - w_reduce;
        if (PW'(BASE_PERIOD) < w_reduce + PW'(MIN_PERIOD)) w_period = PW'(MIN_PERIOD);
    end

    // Compared against the live period so a level change acts on the next edge.
    assign w_tick = (r_state == ST_RUN) && (PW'(r_cnt) >= w_period - PW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               r_cnt <= '0;
        else if (!game_run || r_state == ST_IDLE) r_cnt <= '0;
        else if (r_state == ST_RUN)               r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
    end

    // ---------------- arbitration ----------------
    // New launches only in a steady RUN; a presented command is left alone.
    assign w_launch   = (!r_cmd_valid || cmd_ready) && w_run_stay;
    assign w_sel_grav = w_launch && r_grav_pend;
    assign w_sel_fifo = w_launch && !r_grav_pend && !w_fifo_empty;

    tetris_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_enq),
        .i_din   (w_mv.code),
        .i_pop   (w_sel_fifo),
        .i_flush (w_flush),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kb_ready_d <= 1'b0;
            r_brk_pend   <= 1'b0;
            r_grav_pend  <= 1'b0;
            r_fifo_ovf   <= 1'b0;
            r_paused     <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_code   <= CMD_FALL;
        end else begin
            r_kb_ready_d <= kb_ready;
            r_paused     <= (w_state_nxt == ST_PAUSED);

            if (!game_run)
                r_brk_pend <= 1'b0;
            else if (w_kb_edge && kb_data != SC_EXT)
                r_brk_pend <= !r_brk_pend && (kb_data == SC_BREAK);

            // A tick on the selection edge survives: it re-arms grav_pend.
            if (w_flush)         r_grav_pend <= 1'b0;
            else if (w_tick)     r_grav_pend <= 1'b1;
            else if (w_sel_grav) r_grav_pend <= 1'b0;

            if (!game_run)
                r_fifo_ovf <= 1'b0;
            else if (w_enq && w_fifo_full && !w_sel_fifo)
                r_fifo_ovf <= 1'b1;

            if (!game_run) begin
                r_cmd_valid <= 1'b0;
            end else if (w_sel_grav) begin
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= CMD_FALL;
            end else if (w_sel_fifo) begin
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= cmd_e'(w_fifo_dout);
            end else if (cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign paused    = r_paused;
    assign fifo_ovf  = r_fifo_ovf;

endmodule

// File: tb/tb_tetris_cmd_sched.sv
// Directed bench for tetris_cmd_sched with BASE=100, STEP=10, MIN=20.
// Expected commands are queued when stimulus is driven and popped by the
// negedge monitor on every transfer.
module tb_tetris_cmd_sched;

    localparam logic [1:0] C_FALL = 2'd0;
    localparam logic [1:0] C_LEFT = 2'd1;
    localparam logic [1:0] C_RIGHT = 2'd2;
    localparam logic [1:0] C_ROT  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       game_run;
    logic [3:0] level;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       cmd_ready;
    logic       paused;
    logic       fifo_ovf;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         xfers = 0;
    int         run_len = 0;
    int         last_x = -10;
    logic       prev_stall = 1'b0;
    logic [1:0] prev_code = 2'd0;
    logic [1:0] exp_q[$];

    tetris_cmd_sched #(
        .FIFO_DEPTH (4),
        .CNT_W      (32),
        .BASE_PERIOD(100),
        .STEP_PERIOD(10),
        .MIN_PERIOD (20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .kb_data  (kb_data),
        .kb_ready (kb_ready),
        .game_run (game_run),
        .level    (level),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .cmd_ready(cmd_ready),
        .paused   (paused),
        .fifo_ovf (fifo_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: a transfer happens on the posedge after a negedge that sees valid&&ready.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, cmd_valid}, 32'd1);
                chk("hold_code", {30'd0, cmd_code}, {30'd0, prev_code});
            end
            if (cmd_valid && cmd_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_cmd: observed code %0d expected none", cmd_code);
                end
                if (exp_q.size() != 0) chk("cmd_code", {30'd0, cmd_code}, {30'd0, exp_q.pop_front()});
                xfers   <= xfers + 1;
                run_len <= (cyc == last_x + 1) ? run_len + 1 : 1;
                last_x  <= cyc;
            end
            prev_stall <= cmd_valid && !cmd_ready && game_run;
            prev_code  <= cmd_code;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        kb_data  = b;
        kb_ready = 1'b1;
        @(posedge clk); #1;
        kb_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    // Returns just before the RUN-entry edge (E0).
    task automatic restart(input logic [3:0] lvl);
        game_run = 1'b0;
        level    = lvl;
        step(2);
        game_run = 1'b1;
    endtask

    // n = edges taken until cmd_valid is seen high; n == max on timeout.
    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin @(posedge clk); n++; #1; end while (!cmd_valid && n < max);
    endtask

    initial begin
        int n;
        int x0;
        rst_n = 1'b0; game_run = 1'b0; level = 4'd0;
        kb_ready = 1'b0; kb_data = 8'h00; cmd_ready = 1'b1;
        step(3);
        chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_code", {30'd0, cmd_code}, 32'd0);
        chk("rst_paused", {31'd0, paused}, 32'd0);
        chk("rst_ovf", {31'd0, fifo_ovf}, 32'd0);
        rst_n = 1'b1;
        step(1);

        // Gravity at level 0: tick after 100 counts, valid one edge later.
        exp_q.push_back(C_FALL);
        exp_q.push_back(C_FALL);
        game_run = 1'b1;
        wait_valid(300, n);
        chk("first_fall_lat", n, 102);
        chk("first_fall_code", {30'd0, cmd_code}, {30'd0, C_FALL});
        wait_valid(300, n);
        chk("fall_period", n, 100);
        step(2);

        // Make/break decode: the 1C after F0 is swallowed.
        restart(4'd0); step(1);
        x0 = xfers;
        exp_q.push_back(C_LEFT);
        exp_q.push_back(C_RIGHT);
        send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h23);
        step(4);
        chk("brk_xfers", xfers - x0, 2);
        chk("brk_sb_empty", exp_q.size(), 0);

        // E0 prefix transparent; PAUSE break ignored; PAUSE toggles.
        restart(4'd0); step(1);
        exp_q.push_back(C_RIGHT);
        send_byte(8'hE0); send_byte(8'h23);
        send_byte(8'hF0); send_byte(8'h29);
        chk("brk_pause_ignored", {31'd0, paused}, 32'd0);
        send_byte(8'h29);
        chk("pause_on", {31'd0, paused}, 32'd1);
        send_byte(8'h29);
        chk("pause_off", {31'd0, paused}, 32'd0);
        step(2);
        chk("e0_sb_empty", exp_q.size(), 0);

        // Back-pressure: first LEFT occupies the output slot, next 4 fill the
        // FIFO, the 6th is dropped.
        restart(4'd0); step(1);
        cmd_ready = 1'b0;
        repeat (6) send_byte(8'h1C);
        chk("ovf_set", {31'd0, fifo_ovf}, 32'd1);
        chk("ovf_valid", {31'd0, cmd_valid}, 32'd1);
        chk("ovf_code", {30'd0, cmd_code}, {30'd0, C_LEFT});
        repeat (5) exp_q.push_back(C_LEFT);
        cmd_ready = 1'b1;
        step(8);
        chk("b2b_run", run_len, 5);
        chk("ovf_sb_empty", exp_q.size(), 0);
        restart(4'd0); step(1);
        chk("ovf_cleared_idle", {31'd0, fifo_ovf}, 32'd0);

        // Period clamp and no wrap.
        restart(4'd9);
        exp_q.push_back(C_FALL);
        wait_valid(100, n);
        chk("lvl9_clamp", n, 22);
        step(2);
        restart(4'd15);
        exp_q.push_back(C_FALL);
        wait_valid(100, n);
        chk("lvl15_nowrap", n, 22);
        step(2);
        restart(4'd3);
        exp_q.push_back(C_FALL);
        wait_valid(200, n);
        chk("lvl3_period", n, 72);
        step(2);

        // Level raised with count already past the new period: tick next edge.
        restart(4'd0);
        step(50);
        level = 4'd9;
        exp_q.push_back(C_FALL);
        wait_valid(10, n);
        chk("lvl_change", n, 2);
        step(2);

        // Pause: presented ROTATE survives, queued ROTATE flushed, count frozen at 34.
        restart(4'd0);
        step(30);
        cmd_ready = 1'b0;
        send_byte(8'h1D); send_byte(8'h1D); send_byte(8'h29);
        chk("pause_paused", {31'd0, paused}, 32'd1);
        chk("pause_keep_valid", {31'd0, cmd_valid}, 32'd1);
        chk("pause_keep_code", {30'd0, cmd_code}, {30'd0, C_ROT});
        exp_q.push_back(C_ROT);
        cmd_ready = 1'b1;
        step(150);
        chk("pause_quiet", {31'd0, cmd_valid}, 32'd0);
        chk("pause_sb_empty", exp_q.size(), 0);
        exp_q.push_back(C_FALL);
        kb_data  = 8'h29;
        kb_ready = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; #1; kb_ready = 1'b0; end while (!cmd_valid && n < 200);
        chk("resume_lat", n, 68);
        chk("resume_unpaused", {31'd0, paused}, 32'd0);
        step(2);

        // Typematic repeats.
        restart(4'd0); step(1);
        x0 = xfers;
`ifdef TETRIS_CMD_AUTOREPEAT_EN
        exp_q.push_back(C_ROT);
        repeat (3) send_byte(8'h1D);
        step(3);
        chk("rep_xfers", xfers - x0, 1);
`else
        repeat (3) exp_q.push_back(C_ROT);
        repeat (3) send_byte(8'h1D);
        step(3);
        chk("rep_xfers", xfers - x0, 3);
`endif
        exp_q.push_back(C_ROT);
        send_byte(8'hF0); send_byte(8'h1D); send_byte(8'h1D);
        step(3);
        chk("rep_rearm_sb_empty", exp_q.size(), 0);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
